// File: rtl/ws2812.sv
// ws2812: continuous-refresh serial driver for a WS2812/WS2812B LED chain.
// Each frame sends one 24-bit {G,R,B} word per LED, LED 0 first and MSB first,
// as NRZ pulses on a single registered line. A low latch interval follows.
module ws2812 #(
    parameter int NUM_LEDS = 8,
    parameter int CLK_MHZ  = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [24*NUM_LEDS-1:0]   packed_rgb_data,
    output logic                     data
);

    localparam int T_ON0   = CLK_MHZ * 4 / 10;
    localparam int T_ON1   = CLK_MHZ * 8 / 10;
    localparam int T_BIT   = CLK_MHZ * 125 / 100;
    localparam int T_RESET = CLK_MHZ * 60;

    // The latch interval is the longest count, so it sizes the cycle counter.
    localparam int CNT_W = $clog2(T_RESET + 1);
    localparam int LED_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [CNT_W-1:0] ON0_C        = CNT_W'(T_ON0);
    localparam logic [CNT_W-1:0] ON1_C        = CNT_W'(T_ON1);
    localparam logic [CNT_W-1:0] BIT_LAST_C   = CNT_W'(T_BIT - 1);
    localparam logic [CNT_W-1:0] RESET_LAST_C = CNT_W'(T_RESET - 1);
    localparam logic [LED_W-1:0] LED_LAST_C   = LED_W'(NUM_LEDS - 1);
    localparam logic [4:0]       BIT_TOP_C    = 5'd23;

    typedef enum logic {
        STATE_DATA  = 1'b0,
        STATE_RESET = 1'b1
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [LED_W-1:0]   led_counter;
    logic [LED_W-1:0]   led_counter_d;
    logic [4:0]         bit_counter;
    logic [4:0]         bit_counter_d;
    logic [CNT_W-1:0]   clock_counter;
    logic [CNT_W-1:0]   clock_counter_d;
    logic [23:0]        shift_q;
    logic [23:0]        shift_d;
    logic               data_q;
    logic               data_d;
    logic [LED_W-1:0]   load_idx;
    logic [23:0]        words [NUM_LEDS];

    // Unpack the flat colour bus into one word per LED index.
    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            words[i] = packed_rgb_data[24*i +: 24];
        end
    end

    // State register: all sequential state, asynchronously cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= STATE_RESET;
            led_counter   <= LED_LAST_C;
            bit_counter   <= BIT_TOP_C;
            clock_counter <= '0;
            shift_q       <= 24'h000000;
            data_q        <= 1'b0;
        end else begin
            state         <= state_d;
            led_counter   <= led_counter_d;
            bit_counter   <= bit_counter_d;
            clock_counter <= clock_counter_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
        end
    end

    // Next-state logic: bit/LED sequencing, word loads and latch interval.
    always_comb begin
        state_d         = state;
        led_counter_d   = led_counter;
        bit_counter_d   = bit_counter;
        clock_counter_d = clock_counter + 1'b1;
        shift_d         = shift_q;
        load_idx        = '0;
        case (state)
            STATE_RESET: begin
                led_counter_d = LED_LAST_C;
                bit_counter_d = BIT_TOP_C;
                if (clock_counter == RESET_LAST_C) begin
                    // Word is sampled only here, so an in-flight word never changes.
                    load_idx        = LED_LAST_C - led_counter;
                    shift_d         = words[load_idx];
                    clock_counter_d = '0;
                    state_d         = STATE_DATA;
                end else begin
                    state_d = STATE_RESET;
                end
            end
            STATE_DATA: begin
                if (clock_counter == BIT_LAST_C) begin
                    clock_counter_d = '0;
                    if (bit_counter != 5'd0) begin
                        bit_counter_d = bit_counter - 5'd1;
                        shift_d       = {shift_q[22:0], 1'b0};
                    end else if (led_counter != '0) begin
                        led_counter_d = led_counter - 1'b1;
                        bit_counter_d = BIT_TOP_C;
                        load_idx      = LED_LAST_C - led_counter_d;
                        shift_d       = words[load_idx];
                    end else begin
                        state_d       = STATE_RESET;
                        led_counter_d = LED_LAST_C;
                        bit_counter_d = BIT_TOP_C;
                    end
                end else begin
                    state_d = STATE_DATA;
                end
            end
            default: begin
                state_d         = STATE_RESET;
                led_counter_d   = LED_LAST_C;
                bit_counter_d   = BIT_TOP_C;
                clock_counter_d = '0;
            end
        endcase
    end

    // Output logic: high for the first T_ON0/T_ON1 cycles of each bit, else low.
    always_comb begin
        data_d = 1'b0;
        case (state)
            STATE_DATA: begin
                if (clock_counter < (shift_q[23] ? ON1_C : ON0_C)) begin
                    data_d = 1'b1;
                end else begin
                    data_d = 1'b0;
                end
            end
            STATE_RESET: data_d = 1'b0;
            default:     data_d = 1'b0;
        endcase
    end

    assign data = data_q;

endmodule

// File: tb/tb_ws2812.sv
// Directed bench for ws2812 at CLK_MHZ=12 (T_ON0=4, T_ON1=9, T_BIT=15,
// T_RESET=720), with a 4-LED chain and a second 1-LED chain.
module tb_ws2812;

    logic        clk = 1'b0;
    logic        reset;
    logic        reset1;
    logic [95:0] rgb;
    logic [23:0] rgb1;
    logic        data;
    logic        data1;

    int checks = 0;
    int errors = 0;
    bit timed_out = 1'b0;
    int hi;
    int lo;
    bit ok;

    ws2812 #(.NUM_LEDS(4), .CLK_MHZ(12)) dut (
        .clk(clk), .reset(reset), .packed_rgb_data(rgb), .data(data)
    );

    ws2812 #(.NUM_LEDS(1), .CLK_MHZ(12)) dut1 (
        .clk(clk), .reset(reset1), .packed_rgb_data(rgb1), .data(data1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo_b, input int hi_b);
        checks++;
        assert (obs >= lo_b && obs <= hi_b) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo_b, hi_b);
        end
    endtask

    task automatic report_timeout(input string tag);
        checks++;
        errors++;
        timed_out = 1'b1;
        $error("FAIL timeout %s observed=no_event expected=event", tag);
    endtask

    // Counts low samples from now until a rising edge, then high samples.
    // Sampling is on negedges; returns at the first low sample after the pulse.
    task automatic get_pulse(input bit which, output int hi_n, output int lo_n);
        hi_n = 0;
        lo_n = 0;
        if (!timed_out) begin
            while ((which ? data1 : data) == 1'b0 && lo_n < 3000) begin
                lo_n++;
                @(negedge clk);
            end
            if (lo_n >= 3000) report_timeout("pulse_rise");
            while (!timed_out && (which ? data1 : data) == 1'b1 && hi_n < 200) begin
                hi_n++;
                @(negedge clk);
            end
            if (hi_n >= 200) report_timeout("pulse_fall");
        end
    endtask

    // Checks every pulse of one frame against the expected words.
    // first_lo < 0 means the first gap follows a reset release (720 +/- 1).
    task automatic check_frame(input bit which, input int nleds, input logic [95:0] exp_rgb,
                               input int first_lo, input int chg_a, input logic [95:0] val_a,
                               input int chg_b, input logic [95:0] val_b);
        int h, l, exp_hi, prev_exp_hi;
        logic b;
        prev_exp_hi = 0;
        for (int k = 0; k < 24 * nleds; k++) begin
            get_pulse(which, h, l);
            b = exp_rgb[24 * (k / 24) + 23 - (k % 24)];
            exp_hi = b ? 9 : 4;
            check($sformatf("pulse_high[%0d]", k), h, exp_hi);
            if (k == 0) begin
                if (first_lo < 0) check_range("first_gap_after_reset", l, 719, 721);
                else check("frame_gap", l, first_lo);
            end else begin
                check($sformatf("pulse_low[%0d]", k), l, 15 - prev_exp_hi);
            end
            prev_exp_hi = exp_hi;
            if (k == chg_a) rgb = val_a;
            if (k == chg_b) rgb = val_b;
        end
    endtask

    // Waits for a probed condition: 0 state==DATA, 1 led_counter==0, 2 state==RESET.
    task automatic wait_probe(input int cond, output bit found);
        found = 1'b0;
        for (int n = 0; n < 3000 && !found; n++) begin
            @(negedge clk);
            case (cond)
                0: found = (int'(dut.state) == 0);
                1: found = (int'(dut.led_counter) == 0);
                default: found = (int'(dut.state) == 1);
            endcase
        end
        if (!found) report_timeout($sformatf("probe_%0d", cond));
    endtask

    initial begin
        reset  = 1'b1;
        reset1 = 1'b1;
        rgb    = 96'h0;
        rgb1   = 24'hA5000F;

        // Reset hold.
        repeat (10) @(negedge clk);
        check("reset_data", int'(data), 0);
        check("reset_state", int'(dut.state), 1);
        check("reset_led_counter", int'(dut.led_counter), 3);
        check("reset_bit_counter", int'(dut.bit_counter), 23);
        check("reset_clock_counter", int'(dut.clock_counter), 0);
        check("reset1_led_counter", int'(dut1.led_counter), 0);

        // Release; frame 1 all zero bits.
        reset = 1'b0;
        @(negedge clk);
        check_frame(1'b0, 4, 96'h0, -1, -1, 96'h0, -1, 96'h0);

        // Frame 2: LED0 all ones.
        rgb = {72'h0, 24'hFFFFFF};
        check_frame(1'b0, 4, {72'h0, 24'hFFFFFF}, 731, -1, 96'h0, -1, 96'h0);

        // Frame 3: bit order check.
        rgb = {72'h0, 24'h800001};
        check_frame(1'b0, 4, {72'h0, 24'h800001}, 731, -1, 96'h0, -1, 96'h0);

        // Frame 4: LED0 changed during its own transmission, LED2 during LED1.
        rgb = 96'h0;
        check_frame(1'b0, 4, {24'h0, 24'hC3C3C3, 48'h0}, 731,
                    5,  {72'h0, 24'hFFFFFF},
                    30, {24'h0, 24'hC3C3C3, 24'h0, 24'hFFFFFF});

        // Frame 5: LED0 change now visible.
        check_frame(1'b0, 4, {24'h0, 24'hC3C3C3, 24'h0, 24'hFFFFFF}, 731, -1, 96'h0, -1, 96'h0);

        // Twelve frames: led_counter reaches 0, then state goes to RESET.
        for (int f = 0; f < 12 && !timed_out; f++) begin
            wait_probe(0, ok);
            wait_probe(1, ok);
            check($sformatf("frame%0d_last_led_state", f), int'(dut.state), 0);
            wait_probe(2, ok);
            check($sformatf("frame%0d_reset_led_counter", f), int'(dut.led_counter), 3);
        end

        // Reset asserted mid-bit.
        get_pulse(1'b0, hi, lo);
        lo = 0;
        while (!timed_out && data == 1'b0 && lo < 3000) begin
            lo++;
            @(negedge clk);
        end
        check("midbit_data_high_before_reset", int'(data), 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_data", int'(data), 0);
        check("async_reset_state", int'(dut.state), 1);
        check("async_reset_led_counter", int'(dut.led_counter), 3);
        check("async_reset_clock_counter", int'(dut.clock_counter), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        get_pulse(1'b0, hi, lo);
        check_range("after_midbit_reset_gap", lo, 719, 721);
        check("after_midbit_reset_first_high", hi, 9);

        // Single-LED chain.
        check("led1_hold_data", int'(data1), 0);
        reset1 = 1'b0;
        @(negedge clk);
        check_frame(1'b1, 1, {72'h0, 24'hA5000F}, -1, -1, 96'h0, -1, 96'h0);
        get_pulse(1'b1, hi, lo);
        check("led1_frame_gap", lo, 726);
        check("led1_first_high", hi, 9);
        check("led1_led_counter", int'(dut1.led_counter), 0);
        check("led1_state_data", int'(dut1.state), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
